result_uart_tx: RTL
===================

Name: result_uart_tx

Overview:
Serial reporter for the calculator results held in dmem (suma, resta, mult, div, pow). The processor writes these results and this block reads them out.
- On a start pulse it snapshots all five 32-bit results.
- It transmits them as one framed packet on a 115200-baud 8N1 UART line to a host PC.
- It sits in top beside result_selector and is fed by the same result buses.
- The start pulse comes from the existing edge-detected switch logic.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide). A value below 2 is an elaboration error.
- SYNC_BYTE, 8'hA5: frame header byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse to send a frame.
- result_suma  in  32  result word 0.
- result_resta  in  32  result word 1.
- result_mult  in  32  result word 2.
- result_div  in  32  result word 3.
- result_pow  in  32  result word 4.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset=0: tx=1, busy=0, done=0, FSM=IDLE, all counters 0, snapshot registers 0.
- Frame: 22 bytes in this order.
  - SYNC_BYTE.
  - 20 payload bytes: word 0 through word 4, each word little-endian (bits [7:0] first).
  - CHK = XOR of the 20 payload bytes; SYNC is excluded.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. There is no idle gap between bytes.
- Frame FSM: IDLE -> SYNC -> PAYLOAD (byte index 0..19) -> CHECK -> FINISH -> IDLE.
- Start handling:
  - start=1 in IDLE at edge N: all five words are snapshotted at edge N, busy=1 from N+1, and the tx start bit begins at N+1.
  - start while busy=1 is ignored; it is neither queued nor re-snapshotted.
  - Result inputs changing mid-frame have no effect.
- CHK is accumulated as payload bytes are loaded, so no extra cycles are spent computing it.
- Completion:
  - The full frame takes 220*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
  - On the cycle after the last stop bit ends: done=1 for exactly one cycle, busy=0, tx=1.
  - A start arriving in that same cycle (FINISH/IDLE boundary) is accepted, so back-to-back frames are legal with no gap.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. Bit advance happens on the wrap.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously). The partial frame is abandoned and is not resumed after reset releases.
- All outputs are registered: tx has no combinational path from any input.

Decomposition:
- Package result_uart_pkg holds:
  - typedef enum frame_state_t {IDLE, SYNC, PAYLOAD, CHECK, FINISH}.
  - typedef enum bit_state_t {B_IDLE, B_START, B_DATA, B_STOP}.
  - localparam NUM_WORDS=5 and FRAME_BYTES=22.
- Sub-module uart_tx_byte: a byte serializer with the same clk/reset, CLKS_PER_BIT parameter, a valid/ready handshake on an 8-bit byte, and tx output.
  - ready is high in B_IDLE and during the final cycle of B_STOP, which is what allows gapless bytes.
  - result_uart_tx is then the frame sequencer, snapshot registers and checksum.

Test Plan (bench uses CLK_FREQ=16, BAUD=4, so CLKS_PER_BIT=4; a UART monitor samples at mid-bit):
- Reset check: hold reset=0 for 3 cycles, then release with start=0 for 50 cycles -> tx=1, busy=0, done=0 throughout.
- Basic frame: suma=32'h12345678, all other results 0, one start pulse -> bytes A5 78 56 34 12, then 16×00, then CHK 08. Total 880 cycles; done pulses once; busy falls the same cycle done rises.
- Mixed data: suma=1, resta=FFFFFFFF, mult=0x000000FF, div=0x80000000, pow=0x00010000 -> payload 01 00 00 00 FF FF FF FF FF 00 00 00 00 00 00 80 00 00 01 00. CHK = 01^FF^FF^FF^FF^FF^80^01 = 7F.
- Snapshot and ignore: start, then change suma to 0xDEADBEEF and pulse start again at cycle 100 -> the frame still carries the original suma. No second frame follows and done pulses once.
- Back-to-back: start asserted in the same cycle done=1 -> the second frame's start bit follows immediately, with no idle bit between the frames.
- Mid-frame reset: assert reset=0 at cycle 300 -> tx=1 within the same cycle and busy=0. After release with no start, the line stays idle.

Source files
------------

// File: rtl/result_uart_pkg.sv
// Shared types and constants for the result reporter UART.
package result_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    CHECK,
    FINISH
  } frame_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_t;

  localparam int unsigned NUM_WORDS     = 5;
  localparam int unsigned FRAME_BYTES   = 22;
  localparam int unsigned PAYLOAD_BYTES = NUM_WORDS * 4;
  localparam int unsigned IDX_W         = 5;

  // Byte idx of the payload, where words are packed word 0 in the low bits,
  // so the byte stream is naturally little-endian within each word.
  function automatic logic [7:0] payload_byte(
    input logic [PAYLOAD_BYTES*8-1:0] words,
    input logic [IDX_W-1:0]           idx
  );
    logic [7:0] b;
    if (idx >= IDX_W'(PAYLOAD_BYTES)) begin
      b = '0;
    end else begin
      b = words[{idx, 3'b000} +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake. ready is also raised in
// the last cycle of the stop bit so a waiting byte starts with no idle gap.
module uart_tx_byte
  import result_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  bit_state_t    state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          wrap;

  assign wrap    = (baud_q == BAUD_LAST);
  assign ready_o = (state_q == B_IDLE) || ((state_q == B_STOP) && wrap);
  assign tx_o    = tx_q;

  // Bit-level FSM: baud counter, shift register and registered line output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= B_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else if (valid_i && ready_o) begin
      state_q <= B_START;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= data_i;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        B_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
        end
        B_START: begin
          baud_q <= wrap ? '0 : baud_q + 1'b1;
          if (wrap) begin
            state_q <= B_DATA;
            tx_q    <= shreg_q[0];
          end
        end
        B_DATA: begin
          baud_q <= wrap ? '0 : baud_q + 1'b1;
          if (wrap) begin
            if (bit_q == 3'd7) begin
              state_q <= B_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shreg_q <= shreg_q >> 1;
              tx_q    <= shreg_q[1];
            end
          end
        end
        B_STOP: begin
          baud_q <= wrap ? '0 : baud_q + 1'b1;
          if (wrap) begin
            state_q <= B_IDLE;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= B_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Frame sequencer: snapshots the five calculator results on start and sends
// SYNC, 20 little-endian payload bytes and an XOR checksum over 8N1 UART.
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result_suma,
  input  logic [31:0] result_resta,
  input  logic [31:0] result_mult,
  input  logic [31:0] result_div,
  input  logic [31:0] result_pow,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(PAYLOAD_BYTES);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("result_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end

  frame_state_t                 state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [7:0]                   chk_q;
  logic [PAYLOAD_BYTES*8-1:0]   snap_q;
  logic                         busy_q;
  logic                         done_q;

  logic       ser_valid;
  logic [7:0] ser_data;
  logic       ser_ready;
  logic       fire;
  logic [7:0] cur_byte;

  // idx_q names the next payload byte to hand over; once it reaches the end
  // the accumulated checksum is offered instead.
  assign cur_byte = payload_byte(snap_q, idx_q);
  assign fire     = ser_valid && ser_ready;
  assign busy     = busy_q;
  assign done     = done_q;

  // Choose the byte offered to the serializer; SYNC is offered straight from
  // start so the start bit leaves on the edge that takes the snapshot.
  always_comb begin
    ser_valid = 1'b0;
    ser_data  = SYNC_BYTE;
    case (state_q)
      IDLE, FINISH: ser_valid = start;
      SYNC, PAYLOAD: begin
        ser_valid = 1'b1;
        ser_data  = (idx_q == IDX_END) ? chk_q : cur_byte;
      end
      default: ser_valid = 1'b0;
    endcase
  end

  // Frame FSM with snapshot, checksum accumulation and registered status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      chk_q   <= '0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          done_q <= 1'b0;
          if (start) begin
            snap_q  <= {result_pow, result_div, result_mult, result_resta, result_suma};
            idx_q   <= '0;
            chk_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SYNC;
          end else begin
            state_q <= IDLE;
          end
        end
        SYNC, PAYLOAD: begin
          if (fire) begin
            if (idx_q == IDX_END) begin
              state_q <= CHECK;
            end else begin
              chk_q   <= chk_q ^ cur_byte;
              idx_q   <= idx_q + 1'b1;
              state_q <= PAYLOAD;
            end
          end
        end
        CHECK: begin
          // Ready here can only be the final stop-bit cycle of the checksum.
          if (ser_ready) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk     (clk),
    .reset   (reset),
    .valid_i (ser_valid),
    .data_i  (ser_data),
    .ready_o (ser_ready),
    .tx_o    (tx)
  );

endmodule
